// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents: scan_state_t (BLANK/ON), SEG_BLANK (all segments off, active-high),
// nibble_of() to slice digit k out of a packed digit vector.
package display_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      ON    = 1'b1
   } scan_state_t;

   // All segments dark for an active-high (common-cathode) panel.
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Widest supported panel; callers zero-extend narrower digit vectors.
   localparam int MAX_DIGITS = 8;

   function automatic logic [3:0] nibble_of(input logic [4*MAX_DIGITS-1:0] data,
                                            input logic [2:0]              k);
      return data[{k, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Slot counter: times the blanking and lit phases of one digit slot.
// Latency: strobes are a combinational decode of the registered count.
// Backpressure: none; free-running while not in reset.
//
// Ports: clk, rst (sync, active-high), is_on (1 = current phase is ON),
// blank_done / on_done (high in the last cycle of the respective phase).
module scan_timer #(
   parameter int ON_CYCLES    = 1000,
   parameter int BLANK_CYCLES = 8,
   parameter int CNT_W        = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic is_on,
   output logic blank_done,
   output logic on_done
);

   logic [CNT_W-1:0] cnt;

   assign blank_done = !is_on && (cnt == CNT_W'(BLANK_CYCLES - 1));
   assign on_done    =  is_on && (cnt == CNT_W'(ON_CYCLES - 1));

   // The count restarts whenever a phase ends so each phase starts at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (blank_done || on_done) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment panel sharing one decoder.
// Latency: all outputs registered; new data shows from the frame after LOAD is committed.
// Backpressure: none; LOAD while pending overwrites the pending value (latest wins).
//
// Ports: CLK, RST (sync, active-high), LOAD + DATA_IN + BLANK_MASK (pending buffer write),
// NIBBLE -> shared decoder, SEG_IN <- decoder, SEG_OUT / DIG_EN -> panel,
// LOAD_ACK (one-cycle pulse when pending data becomes active).
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int ON_CYCLES      = 1000,
   parameter int BLANK_CYCLES   = 8,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    LOAD,
   input  logic [4*NUM_DIGITS-1:0] DATA_IN,
   input  logic [NUM_DIGITS-1:0]   BLANK_MASK,
   output logic [3:0]              NIBBLE,
   input  logic [6:0]              SEG_IN,
   output logic [6:0]              SEG_OUT,
   output logic [NUM_DIGITS-1:0]   DIG_EN,
   output logic                    LOAD_ACK
);

   localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IDX_W   = $clog2(NUM_DIGITS);

   localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;

   scan_state_t             state;
   logic [IDX_W-1:0]        idx;
   logic [4*NUM_DIGITS-1:0] active_data;
   logic [NUM_DIGITS-1:0]   active_mask;
   logic [4*NUM_DIGITS-1:0] pend_data;
   logic [NUM_DIGITS-1:0]   pend_mask;
   logic                    pend_flag;

   logic                    blank_done;
   logic                    on_done;
   logic                    last_digit;
   logic                    frame_end;
   logic [IDX_W-1:0]        idx_next;
   logic [6:0]              seg_drive;

   scan_timer #(
      .ON_CYCLES    (ON_CYCLES),
      .BLANK_CYCLES (BLANK_CYCLES),
      .CNT_W        (CNT_W)
   ) u_timer (
      .clk        (CLK),
      .rst        (RST),
      .is_on      (state == ON),
      .blank_done (blank_done),
      .on_done    (on_done)
   );

   assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
   assign frame_end  = on_done && last_digit;
   assign idx_next   = last_digit ? '0 : idx + IDX_W'(1);
   assign seg_drive  = (SEG_ACTIVE_LOW != 0) ? ~SEG_IN : SEG_IN;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= BLANK;
         idx         <= '0;
         active_data <= '0;
         active_mask <= '0;
         pend_data   <= '0;
         pend_mask   <= '0;
         pend_flag   <= 1'b0;
         NIBBLE      <= 4'h0;
         SEG_OUT     <= SEG_OFF;
         DIG_EN      <= '0;
         LOAD_ACK    <= 1'b0;
      end else begin
         LOAD_ACK <= 1'b0;

         if (LOAD) begin
            pend_data <= DATA_IN;
            pend_mask <= BLANK_MASK;
            pend_flag <= 1'b1;
         end

         case (state)
            BLANK: begin
               // Decoder has had the whole blanking phase to settle on NIBBLE.
               if (blank_done) begin
                  state <= ON;
                  if (active_mask[idx]) begin
                     DIG_EN  <= '0;
                     SEG_OUT <= SEG_OFF;
                  end else begin
                     DIG_EN  <= NUM_DIGITS'(1) << idx;
                     SEG_OUT <= seg_drive;
                  end
               end
            end
            ON: begin
               if (on_done) begin
                  state   <= BLANK;
                  DIG_EN  <= '0;
                  SEG_OUT <= SEG_OFF;
                  idx     <= idx_next;
                  if (frame_end && pend_flag) begin
                     // Commit the value pending before this edge; a LOAD on this
                     // same cycle stays pending for the next frame end.
                     active_data <= pend_data;
                     active_mask <= pend_mask;
                     pend_flag   <= LOAD;
                     LOAD_ACK    <= 1'b1;
                     NIBBLE      <= nibble_of(32'(pend_data), 3'(idx_next));
                  end else begin
                     NIBBLE      <= nibble_of(32'(active_data), 3'(idx_next));
                  end
               end else if (!active_mask[idx]) begin
                  SEG_OUT <= seg_drive;
               end
            end
            default: state <= BLANK;
         endcase
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: two instances (active-high and active-low
// segments) sharing the same stimulus, 4 digits, ON=4, BLANK=2 (slot 6, frame 24).
module tb_display_scan_ctrl;

   logic        clk;
   logic        rst;
   logic        load;
   logic [15:0] data_in;
   logic [3:0]  blank_mask;

   logic [3:0]  nibble, nibble_al;
   logic [6:0]  seg_in, seg_in_al;
   logic [6:0]  seg_out, seg_out_al;
   logic [3:0]  dig_en, dig_en_al;
   logic        load_ack, load_ack_al;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   // Expected display contents as seen by the panel from the current cycle on.
   logic [15:0] data_now;
   logic [3:0]  mask_now;

   logic [27:0] got;
   logic [27:0] exp;

   assign seg_in    = {3'b000, nibble};
   assign seg_in_al = {3'b000, nibble_al};

   display_scan_ctrl #(
      .NUM_DIGITS(4), .ON_CYCLES(4), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(0)
   ) dut (
      .CLK(clk), .RST(rst), .LOAD(load), .DATA_IN(data_in), .BLANK_MASK(blank_mask),
      .NIBBLE(nibble), .SEG_IN(seg_in), .SEG_OUT(seg_out), .DIG_EN(dig_en),
      .LOAD_ACK(load_ack)
   );

   display_scan_ctrl #(
      .NUM_DIGITS(4), .ON_CYCLES(4), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1)
   ) dut_al (
      .CLK(clk), .RST(rst), .LOAD(load), .DATA_IN(data_in), .BLANK_MASK(blank_mask),
      .NIBBLE(nibble_al), .SEG_IN(seg_in_al), .SEG_OUT(seg_out_al), .DIG_EN(dig_en_al),
      .LOAD_ACK(load_ack_al)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index since the last reset edge.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // Digit enables must never be multi-hot on either instance.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (!$onehot0(dig_en) || !$onehot0(dig_en_al)) begin
            errors++;
            $display("FAIL onehot cyc=%0d dig_en=%b dig_en_al=%b required=one-hot or zero",
                     cyc, dig_en, dig_en_al);
         end
      end
   end

   // Expected values for cycle c after reset: slot = (c%24)/6, lit when (c%6) >= 2.
   function automatic logic [3:0] exp_dig(input int c, input logic [3:0] m);
      int s = (c % 24) / 6;
      int p = c % 6;
      return (p >= 2 && !m[s]) ? (4'b0001 << s) : 4'b0000;
   endfunction

   function automatic logic [3:0] exp_nib(input int c, input logic [15:0] d);
      int s = (c % 24) / 6;
      return d[4*s +: 4];
   endfunction

   function automatic logic [6:0] exp_seg(input int c, input logic [15:0] d,
                                          input logic [3:0] m, input bit al);
      int s = (c % 24) / 6;
      int p = c % 6;
      logic [6:0] v;
      v = (p >= 2 && !m[s]) ? {3'b000, d[4*s +: 4]} : 7'h00;
      return al ? ~v : v;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (dig_en !== 4'b0000 || load_ack !== 1'b0) begin
         errors++;
         $display("FAIL reset_en_ack dig_en=%b ack=%b required 0000/0", dig_en, load_ack);
      end
      checks++;
      if (seg_out !== 7'h00) begin
         errors++;
         $display("FAIL reset_seg got=%h required=00", seg_out);
      end
      checks++;
      if (seg_out_al !== 7'h7F) begin
         errors++;
         $display("FAIL reset_seg_al got=%h required=7f", seg_out_al);
      end
      checks++;
      if (nibble !== 4'h0) begin
         errors++;
         $display("FAIL reset_nibble got=%h required=0", nibble);
      end
   endtask

   // Frame 0 shows zeros, 4321 commits at the first frame end (cycle 24).
   task automatic test_scan();
      data_now = 16'h0000;
      mask_now = 4'b0000;
      for (int c = 0; c <= 47; c++) begin
         load = 1'b0;
         if (c == 0) begin load = 1'b1; data_in = 16'h4321; blank_mask = 4'b0000; end
         if (c == 24) data_now = 16'h4321;
         got = {load_ack, load_ack_al, dig_en, dig_en_al, seg_out, seg_out_al, nibble};
         exp = {c == 24, c == 24, exp_dig(c, mask_now), exp_dig(c, mask_now),
                exp_seg(c, data_now, mask_now, 0), exp_seg(c, data_now, mask_now, 1),
                exp_nib(c, data_now)};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL scan c=%0d got=%h required=%h", c, got, exp);
         end
         @(negedge clk);
      end
   endtask

   // Digit 2 masked from frame 3 on.
   task automatic test_mask();
      for (int c = 48; c <= 95; c++) begin
         load = 1'b0;
         if (c == 48) begin load = 1'b1; data_in = 16'h4321; blank_mask = 4'b0100; end
         if (c == 72) mask_now = 4'b0100;
         got = {load_ack, load_ack_al, dig_en, dig_en_al, seg_out, seg_out_al, nibble};
         exp = {c == 72, c == 72, exp_dig(c, mask_now), exp_dig(c, mask_now),
                exp_seg(c, data_now, mask_now, 0), exp_seg(c, data_now, mask_now, 1),
                exp_nib(c, data_now)};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL mask c=%0d got=%h required=%h", c, got, exp);
         end
         @(negedge clk);
      end
   endtask

   // Two LOADs in one frame: one ack at 120, the later value (all B) is shown.
   task automatic test_double_load();
      for (int c = 96; c <= 142; c++) begin
         load = 1'b0;
         if (c == 96)  begin load = 1'b1; data_in = 16'hAAAA; blank_mask = 4'b0000; end
         if (c == 100) begin load = 1'b1; data_in = 16'hBBBB; blank_mask = 4'b0000; end
         if (c == 120) begin data_now = 16'hBBBB; mask_now = 4'b0000; end
         got = {load_ack, load_ack_al, dig_en, dig_en_al, seg_out, seg_out_al, nibble};
         exp = {c == 120, c == 120, exp_dig(c, mask_now), exp_dig(c, mask_now),
                exp_seg(c, data_now, mask_now, 0), exp_seg(c, data_now, mask_now, 1),
                exp_nib(c, data_now)};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL double_load c=%0d got=%h required=%h", c, got, exp);
         end
         @(negedge clk);
      end
   endtask

   // LOAD on frame-end cycles: 143 (nothing pending) acks at 168, not 144;
   // 167 (1234 pending) commits 1234 at 168 and 8765 at 192.
   task automatic test_frame_end_load();
      for (int c = 143; c <= 215; c++) begin
         load = 1'b0;
         if (c == 143) begin load = 1'b1; data_in = 16'h1234; blank_mask = 4'b0000; end
         if (c == 167) begin load = 1'b1; data_in = 16'h8765; blank_mask = 4'b0000; end
         if (c == 168) data_now = 16'h1234;
         if (c == 192) data_now = 16'h8765;
         got = {load_ack, load_ack_al, dig_en, dig_en_al, seg_out, seg_out_al, nibble};
         exp = {c == 168 || c == 192, c == 168 || c == 192,
                exp_dig(c, mask_now), exp_dig(c, mask_now),
                exp_seg(c, data_now, mask_now, 0), exp_seg(c, data_now, mask_now, 1),
                exp_nib(c, data_now)};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL frame_end_load c=%0d got=%h required=%h", c, got, exp);
         end
         @(negedge clk);
      end
   endtask

   // Reset during digit 2 ON with 9999 pending: outputs clear, pending discarded.
   task automatic test_reset_mid();
      for (int c = 216; c <= 231; c++) begin
         load = 1'b0;
         if (c == 221) begin load = 1'b1; data_in = 16'h9999; blank_mask = 4'b1111; end
         got = {load_ack, load_ack_al, dig_en, dig_en_al, seg_out, seg_out_al, nibble};
         exp = {1'b0, 1'b0, exp_dig(c, mask_now), exp_dig(c, mask_now),
                exp_seg(c, data_now, mask_now, 0), exp_seg(c, data_now, mask_now, 1),
                exp_nib(c, data_now)};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL pre_reset c=%0d got=%h required=%h", c, got, exp);
         end
         if (c != 231) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({load_ack, dig_en, seg_out, nibble} !== 16'h0000) begin
         errors++;
         $display("FAIL mid_reset ack=%b dig_en=%b seg=%h nib=%h required all 0",
                  load_ack, dig_en, seg_out, nibble);
      end
      checks++;
      if (seg_out_al !== 7'h7F || dig_en_al !== 4'b0000) begin
         errors++;
         $display("FAIL mid_reset_al seg=%h dig_en=%b required 7f/0000", seg_out_al, dig_en_al);
      end
      data_now = 16'h0000;
      mask_now = 4'b0000;
      for (int c = 0; c <= 47; c++) begin
         got = {load_ack, load_ack_al, dig_en, dig_en_al, seg_out, seg_out_al, nibble};
         exp = {1'b0, 1'b0, exp_dig(c, mask_now), exp_dig(c, mask_now),
                exp_seg(c, data_now, mask_now, 0), exp_seg(c, data_now, mask_now, 1),
                exp_nib(c, data_now)};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL post_reset c=%0d got=%h required=%h", c, got, exp);
         end
         @(negedge clk);
      end
   endtask

   // Ten frames of FEDC with digit 0 masked; exercises active-low inversion.
   task automatic test_active_low();
      for (int c = 48; c <= 287; c++) begin
         load = 1'b0;
         if (c == 48) begin load = 1'b1; data_in = 16'hFEDC; blank_mask = 4'b0001; end
         if (c == 72) begin data_now = 16'hFEDC; mask_now = 4'b0001; end
         got = {load_ack, load_ack_al, dig_en, dig_en_al, seg_out, seg_out_al, nibble};
         exp = {c == 72, c == 72, exp_dig(c, mask_now), exp_dig(c, mask_now),
                exp_seg(c, data_now, mask_now, 0), exp_seg(c, data_now, mask_now, 1),
                exp_nib(c, data_now)};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL active_low c=%0d got=%h required=%h", c, got, exp);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst        = 1'b1;
      load       = 1'b0;
      data_in    = 16'h0000;
      blank_mask = 4'b0000;
      data_now   = 16'h0000;
      mask_now   = 4'b0000;
      do_reset();
      test_reset();
      test_scan();
      test_mask();
      test_double_load();
      test_frame_end_load();
      test_reset_mid();
      test_active_low();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit common-segment 7-segment display.
- Shares one external combinational hex-to-segment decoder among NUM_DIGITS digits: presents one nibble at a time, captures the decoded segments, and drives one-hot digit enables.
- Adds a blanking guard between digits to prevent ghosting.
- Double-buffers display data so new values take effect only at frame boundaries (no tearing).

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- ON_CYCLES, 1000, clock cycles each digit is lit per slot (>=1).
- BLANK_CYCLES, 8, clock cycles of blanking before each digit (>=1). Also the decoder settle time.
- SEG_ACTIVE_LOW, 0, 1 inverts SEG_OUT for common-anode panels.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- LOAD  in  1  one-cycle strobe that captures DATA_IN and BLANK_MASK into the pending buffer.
- DATA_IN  in  4*NUM_DIGITS  digit nibbles; digit k is bits [4k+3:4k], digit 0 in the LSBs.
- BLANK_MASK  in  NUM_DIGITS  1 = digit k is kept dark.
- NIBBLE  out  4  to the shared decoder inputs (A=bit3 .. D=bit0).
- SEG_IN  in  7  from the shared decoder outputs (D0..D6).
- SEG_OUT  out  7  registered segment drive to the panel.
- DIG_EN  out  NUM_DIGITS  one-hot, active-high digit enable.
- LOAD_ACK  out  1  one-cycle pulse when pending data is committed to the active buffer.

Behaviour:
- Reset (sync, takes effect on the next CLK edge, including mid-frame):
  - State BLANK, digit index 0, slot counter 0.
  - Active and pending buffers cleared to 0; pending flag cleared. Any uncommitted LOAD is discarded.
  - Outputs: NIBBLE=0, DIG_EN=0, SEG_OUT=blank pattern (7'b0, or 7'h7F if SEG_ACTIVE_LOW), LOAD_ACK=0.
- State machine (2 states):
  - BLANK: lasts BLANK_CYCLES cycles. DIG_EN=0, SEG_OUT=blank. NIBBLE=active[idx] for the whole phase.
  - BLANK -> ON when the counter reaches BLANK_CYCLES-1; the counter is then cleared.
  - ON: lasts ON_CYCLES cycles. NIBBLE held. SEG_OUT = SEG_IN registered (polarity per SEG_ACTIVE_LOW). DIG_EN = one-hot(idx), or all 0 with SEG_OUT=blank if active_mask[idx]=1.
  - ON -> BLANK when the counter reaches ON_CYCLES-1. idx increments, wrapping NUM_DIGITS-1 -> 0.
- Output timing:
  - All outputs are registered.
  - DIG_EN and SEG_OUT are high/valid for exactly ON_CYCLES consecutive cycles per slot, beginning one cycle after the last BLANK cycle.
  - Slot = BLANK_CYCLES+ON_CYCLES cycles. Frame = NUM_DIGITS*slot cycles.
  - DIG_EN is never multi-hot, and is never non-zero during a BLANK cycle.
- Load and commit:
  - LOAD=1 writes DATA_IN/BLANK_MASK to pending and sets the pending flag.
  - LOAD while pending is already set overwrites it (latest wins; the earlier value is lost, with no ack).
  - Frame end = the ON->BLANK transition with idx=NUM_DIGITS-1. At frame end, if the pending flag is set: active<=pending, flag cleared, LOAD_ACK=1 for the next cycle only.
  - LOAD coinciding with the frame-end cycle: the previous pending value (if any) commits. The new data lands in pending with the flag set, and commits at the following frame end.
  - LOAD with no pending data at frame end: no commit, no ack.
- Counters: slot counter width = clog2(max(ON_CYCLES,BLANK_CYCLES)); idx width = clog2(NUM_DIGITS). No other arithmetic.

Decomposition:
- Package display_pkg:
  - scan_state_t enum {BLANK, ON}.
  - SEG_BLANK constant.
  - Helper function for the nibble slice of digit k.
- Sub-module scan_timer: parameterised slot counter producing blank_done and on_done strobes. Instantiated once.
- The shared decoder is instantiated by the parent, outside this block.

Test Plan:
- Bench parameters for all cases: NUM_DIGITS=4, ON_CYCLES=4, BLANK_CYCLES=2. SEG_IN modelled as {3'b0,NIBBLE}.
- Reset release, then LOAD DATA_IN=16'h4321, mask 0 -> LOAD_ACK at the first frame end (cycle 24 after reset). From then on, DIG_EN cycles 0001,0010,0100,1000, each for 4 cycles with 2 dark cycles between; SEG_OUT=1,2,3,4 during the matching slots.
- BLANK_MASK=4'b0100 committed -> DIG_EN=0 and SEG_OUT=0 during digit 2's ON window; other digits unaffected.
- Two LOADs (16'hAAAA, then 16'hBBBB) within one frame -> a single LOAD_ACK, and the display shows B on all digits. Separately, LOAD asserted exactly on the frame-end cycle -> ack arrives one frame later.
- RST asserted mid-ON of digit 2 with a LOAD pending -> next cycle all outputs are at reset values. After release, scanning restarts at digit 0 showing 0 and no LOAD_ACK occurs.
- SEG_ACTIVE_LOW=1 -> SEG_OUT=7'h7F during blanking and the inverted SEG_IN when lit. Assertion check: DIG_EN is never multi-hot across 10 frames.
